// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers hex digits and decimal points from a multiplexed,
// active-low 7-segment bus and hands out complete frames over VALID/READY.
module seg7_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        nHEX,
  input  logic [NDIG-1:0]   nSEL,
  output logic [4*NDIG-1:0] DIGITS,
  output logic [NDIG-1:0]   DPS,
  output logic [NDIG-1:0]   ERR,
  output logic              VALID,
  input  logic              READY,
  output logic              SEL_ERR
);

  // state      | meaning
  // FRAME_IDLE | nothing presented, VALID low
  // FRAME_HELD | frame on DIGITS/DPS/ERR, VALID high until taken with READY
  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_HELD = 1'b1
  } frame_state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  frame_state_t      state_q, state_d;
  logic [7:0]        s_hex_q, s_hex_d;
  logic [7:0]        p_hex_q, p_hex_d;
  logic [NDIG-1:0]   s_sel_q, s_sel_d;
  logic [NDIG-1:0]   p_sel_q, p_sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_err_q, sel_err_d;
  logic [4*NDIG-1:0] shd_val_q, shd_val_d;
  logic [NDIG-1:0]   shd_dp_q, shd_dp_d;
  logic [NDIG-1:0]   shd_err_q, shd_err_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   dps_q, dps_d;
  logic [NDIG-1:0]   err_q, err_d;

  logic [3:0]        sel_lows;
  logic              sel_legal;
  logic              same;
  logic              commit;
  logic [NDIG-1:0]   commit_mask;
  logic [NDIG-1:0]   seen_m;
  logic [4:0]        dec;
  logic              frame_full;
  logic              take;

  // {err, value} for an active-high gfedcba pattern; unknown shapes give 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Input sampling, select legality and run-length qualification of the sampled pattern.
  always_comb begin
    s_hex_d  = nHEX;
    s_sel_d  = nSEL;
    p_hex_d  = s_hex_q;
    p_sel_d  = s_sel_q;
    sel_lows = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!s_sel_q[i]) sel_lows = sel_lows + 4'd1;
    end
    sel_legal = (sel_lows == 4'd1);
    sel_err_d = (sel_lows > 4'd1);
    same      = (s_hex_q == p_hex_q) && (s_sel_q == p_sel_q);
    if (!sel_legal)              cnt_d = '0;
    else if (!same)              cnt_d = 4'd1;
    else if (cnt_q == STABLE_C)  cnt_d = cnt_q;
    else                         cnt_d = cnt_q + 4'd1;
    // A saturated run of the same pattern must not commit again.
    commit      = sel_legal && (cnt_d == STABLE_C) && !(same && (cnt_q == STABLE_C));
    commit_mask = commit ? ~s_sel_q : '0;
    dec         = seg_decode(~s_hex_q[6:0]);
  end

  // Shadow update, frame assembly and the VALID/READY presentation FSM.
  always_comb begin
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    shd_err_d = shd_err_q;
    for (int i = 0; i < NDIG; i++) begin
      if (commit_mask[i]) begin
        shd_val_d[4*i +: 4] = dec[3:0];
        shd_dp_d[i]         = ~s_hex_q[7];
        shd_err_d[i]        = dec[4];
      end
    end
    seen_m     = seen_q | commit_mask;
    frame_full = &seen_m;
    take       = (state_q == FRAME_IDLE) || READY;
    state_d    = state_q;
    digits_d   = digits_q;
    dps_d      = dps_q;
    err_d      = err_q;
    seen_d     = seen_m;
    if (frame_full && take) begin
      digits_d = shd_val_d;
      dps_d    = shd_dp_d;
      err_d    = shd_err_d;
      state_d  = FRAME_HELD;
      // A commit that lands while an older full frame was waiting starts the next frame.
      seen_d   = (&seen_q) ? commit_mask : '0;
    end else if ((state_q == FRAME_HELD) && READY) begin
      state_d = FRAME_IDLE;
    end
  end

  // Datapath registers; sample stage resets to a blanked bus so no select error follows reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_hex_q   <= '1;
      s_sel_q   <= '1;
      p_hex_q   <= '1;
      p_sel_q   <= '1;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      shd_err_q <= '0;
      seen_q    <= '0;
      digits_q  <= '0;
      dps_q     <= '0;
      err_q     <= '0;
    end else begin
      s_hex_q   <= s_hex_d;
      s_sel_q   <= s_sel_d;
      p_hex_q   <= p_hex_d;
      p_sel_q   <= p_sel_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      shd_err_q <= shd_err_d;
      seen_q    <= seen_d;
      digits_q  <= digits_d;
      dps_q     <= dps_d;
      err_q     <= err_d;
    end
  end

  // Frame presentation state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= FRAME_IDLE;
    else     state_q <= state_d;
  end

  assign DIGITS  = digits_q;
  assign DPS     = dps_q;
  assign ERR     = err_q;
  assign VALID   = (state_q == FRAME_HELD);
  assign SEL_ERR = sel_err_q;

endmodule
